// File: rtl/demux1to4_buf_n_pkg.sv
// Shared datapath-library definitions: lane addressing for the 4-way
// selector and demultiplexer blocks.
package demux1to4_buf_n_pkg;

  localparam int ADDRESS = 2;
  localparam int LANES   = 2 ** ADDRESS;

  typedef logic [ADDRESS-1:0] lane_idx_t;

  // Round-robin successor; the natural 2-bit wrap gives 3 -> 0.
  function automatic lane_idx_t next_lane(input lane_idx_t cur);
    return cur + 1'b1;
  endfunction

endpackage

// File: rtl/demux1to4_buf_n_lane_slot.sv
// One-entry lane buffer: holds a word until its consumer takes it.
// A load in the same cycle as a drain replaces the word without a bubble.
module lane_slot_n #(
  parameter int n = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load,
  input  logic         drain,
  input  logic [n-1:0] din,
  output logic [n-1:0] dout,
  output logic         full
);

  // Data register and full flag; data holds its last value after a drain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dout <= '0;
      full <= 1'b0;
    end else if (load) begin
      dout <= din;
      full <= 1'b1;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/demux1to4_buf_n.sv
// Registered 1-to-4 demultiplexer with per-lane one-entry buffers.
// The destination is an explicit select or a round-robin pointer that
// never skips a full lane, so auto mode preserves strict lane ordering.
module demux1to4_buf_n
  import demux1to4_buf_n_pkg::*;
#(
  parameter int n       = 4,
  parameter int address = ADDRESS
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [n-1:0]       data_i,
  input  logic [address-1:0] sel_i,
  input  logic               auto_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic [n-1:0]       data_o [0:LANES-1],
  output logic [LANES-1:0]   valid_o,
  input  logic [LANES-1:0]   ready_i,
  output lane_idx_t          lane_o
);

  lane_idx_t        dest;
  lane_idx_t        lane_reg;
  lane_idx_t        lane_next;
  logic             accept;
  logic [LANES-1:0] load;
  logic [LANES-1:0] drain;

  // Destination lane: pointer in auto mode, otherwise the explicit select.
  always_comb begin
    dest = auto_i ? lane_reg : sel_i;
  end

  // Ready only depends on the chosen lane having room (or emptying now).
  assign ready_o = !valid_o[dest] || ready_i[dest];
  assign accept  = valid_i && ready_o;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign load[gi]  = accept && (dest == lane_idx_t'(gi));
      assign drain[gi] = valid_o[gi] && ready_i[gi];

      lane_slot_n #(
        .n(n)
      ) u_slot (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .load  (load[gi]),
        .drain (drain[gi]),
        .din   (data_i),
        .dout  (data_o[gi]),
        .full  (valid_o[gi])
      );
    end
  endgenerate

  // Pointer advances only on an accepted word while in auto mode.
  always_comb begin
    lane_next = lane_reg;
    if (accept && auto_i) begin
      lane_next = next_lane(lane_reg);
    end
  end

  // Round-robin pointer register; keeps its value across mode changes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lane_reg <= '0;
    end else begin
      lane_reg <= lane_next;
    end
  end

  assign lane_o = lane_reg;

endmodule

// File: tb/tb_demux1to4_buf_n.sv
// Directed testbench for demux1to4_buf_n.
module tb_demux1to4_buf_n;

  logic       clk_i;
  logic       rst_i;
  logic [3:0] data_i;
  logic [1:0] sel_i;
  logic       auto_i;
  logic       valid_i;
  logic       ready_o;
  logic [3:0] data_o [0:3];
  logic [3:0] valid_o;
  logic [3:0] ready_i;
  logic [1:0] lane_o;

  int n_tests = 0;
  int n_fail  = 0;
  int sent_cnt = 0;
  int recv_cnt = 0;

  logic       stall_prev = 1'b0;
  logic [3:0] data_prev  = '0;

  demux1to4_buf_n #(
    .n(4),
    .address(2)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .data_i  (data_i),
    .sel_i   (sel_i),
    .auto_i  (auto_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .lane_o  (lane_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Count words entering and leaving the block.
  always @(posedge clk_i) begin
    if (!rst_i) begin
      if (valid_i && ready_o) sent_cnt <= sent_cnt + 1;
      recv_cnt <= recv_cnt + $countones(valid_o & ready_i);
    end
  end

  // Sender rule: data stays stable while stalled.
  always @(posedge clk_i) begin
    if (!rst_i && stall_prev && valid_i && (data_i !== data_prev))
      $error("sender changed data_i while stalled");
    stall_prev <= valid_i && !ready_o;
    data_prev  <= data_i;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; data_i = '0; sel_i = '0; auto_i = 1'b0; ready_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_valid", valid_o, 4'b0000);
    check("rst_lane", lane_o, 0);
    for (int k = 0; k < 4; k++) check("rst_data", data_o[k], 0);
    rst_i = 1'b0;

    // Select routing
    data_i = 4'hA; sel_i = 2'd1; valid_i = 1'b1;
    #1 check("sel_rdy_a", ready_o, 1);
    tick;
    check("sel_valid_a", valid_o, 4'b0010);
    check("sel_data1", data_o[1], 4'hA);
    data_i = 4'hB; sel_i = 2'd3;
    #1 check("sel_rdy_b", ready_o, 1);
    tick;
    check("sel_valid_b", valid_o, 4'b1010);
    check("sel_data3", data_o[3], 4'hB);
    check("sel_data1_hold", data_o[1], 4'hA);

    // Full-lane stall
    data_i = 4'hC; sel_i = 2'd2;
    tick;
    check("stall_fill", valid_o, 4'b1110);
    check("stall_fill_d", data_o[2], 4'hC);
    data_i = 4'hD;
    #1 check("stall_rdy0", ready_o, 0);
    tick;
    check("stall_hold", data_o[2], 4'hC);
    check("stall_valid", valid_o, 4'b1110);
    sel_i = 2'd0;
    #1 check("stall_resel", ready_o, 1);
    sel_i = 2'd2;
    #1 check("stall_back", ready_o, 0);
    ready_i = 4'b0100;
    #1 check("stall_release", ready_o, 1);
    tick;
    check("stall_new", data_o[2], 4'hD);
    check("stall_nobubble", valid_o, 4'b1110);
    valid_i = 1'b0;
    tick;
    check("drain2_valid", valid_o, 4'b1010);
    check("drain2_data", data_o[2], 4'hD);
    ready_i = 4'b1111;
    tick;
    check("drain_all", valid_o, 4'b0000);

    // Round robin
    auto_i = 1'b1; valid_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      data_i = 4'(k + 1);
      #1 check("rr_lane", lane_o, k % 4);
      check("rr_rdy", ready_o, 1);
      tick;
      check("rr_valid", valid_o, 32'(1 << (k % 4)));
      check("rr_data", data_o[k % 4], k + 1);
    end
    check("rr_lane_end", lane_o, 2);
    valid_i = 1'b0;
    tick;
    check("rr_empty", valid_o, 4'b0000);

    // Round-robin no-skip
    ready_i = 4'b1101; valid_i = 1'b1;
    for (int k = 0; k < 7; k++) begin
      data_i = 4'(7 + k);
      tick;
    end
    check("ns_lane", lane_o, 1);
    check("ns_valid", valid_o, 4'b0011);
    check("ns_data1", data_o[1], 4'hA);
    data_i = 4'hE;
    for (int c = 0; c < 5; c++) begin
      #1 check("ns_rdy0", ready_o, 0);
      check("ns_lane_hold", lane_o, 1);
      tick;
      check("ns_data_hold", data_o[1], 4'hA);
    end
    ready_i = 4'b1111;
    #1 check("ns_release", ready_o, 1);
    tick;
    check("ns_new", data_o[1], 4'hE);
    check("ns_valid_new", valid_o, 4'b0010);
    check("ns_lane_next", lane_o, 2);
    valid_i = 1'b0;
    tick;
    check("ns_empty", valid_o, 4'b0000);

    // Simultaneous drain / refill
    auto_i = 1'b0; ready_i = 4'b0000; valid_i = 1'b1;
    sel_i = 2'd0; data_i = 4'h3;
    tick;
    sel_i = 2'd3; data_i = 4'h5;
    tick;
    check("sim_fill", valid_o, 4'b1001);
    ready_i = 4'b1001; data_i = 4'h9;
    #1 check("sim_rdy", ready_o, 1);
    tick;
    check("sim_valid", valid_o, 4'b1000);
    check("sim_data3", data_o[3], 4'h9);
    check("sim_data0_hold", data_o[0], 4'h3);
    valid_i = 1'b0; ready_i = 4'b1111;
    tick;
    check("sim_empty", valid_o, 4'b0000);
    check("sel_lane_kept", lane_o, 2);
    check("sb_sent", sent_cnt, 21);
    check("sb_recv", recv_cnt, 21);

    // Asynchronous reset mid-cycle with lanes full and lane_o=2
    ready_i = 4'b0000; valid_i = 1'b1;
    sel_i = 2'd0; data_i = 4'h1;
    tick;
    sel_i = 2'd1; data_i = 4'h2;
    tick;
    valid_i = 1'b0;
    check("pre_rst_valid", valid_o, 4'b0011);
    check("pre_rst_lane", lane_o, 2);
    #2 rst_i = 1'b1;
    #1;
    check("arst_valid", valid_o, 4'b0000);
    check("arst_lane", lane_o, 0);
    for (int k = 0; k < 4; k++) check("arst_data", data_o[k], 0);
    tick;
    rst_i = 1'b0;
    valid_i = 1'b1; sel_i = 2'd2; data_i = 4'h7;
    #1 check("post_rst_rdy", ready_o, 1);
    tick;
    check("post_rst_valid", valid_o, 4'b0100);
    check("post_rst_data", data_o[2], 4'h7);
    valid_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
